// File: rtl/ar_id_remapper.sv
// AXI AR-channel ID remapper: allocates a unique ID per accepted request and
// queues the remapped request in a 2-entry FIFO feeding the slave-side AR port.
module ar_id_remapper #(
    parameter int ID_WIDTH = 4,
    parameter int UID_W    = 6,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_ar_valid,
    output logic                s_ar_ready,
    input  logic [ID_WIDTH-1:0] s_ar_id,
    input  logic [ADDR_W-1:0]   s_ar_addr,
    input  logic [7:0]          s_ar_len,
    input  logic [2:0]          s_ar_size,
    input  logic [1:0]          s_ar_burst,
    output logic                alloc_req,
    output logic [ID_WIDTH-1:0] in_orig_id,
    input  logic                alloc_gnt,
    input  logic [UID_W-1:0]    unique_id,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [UID_W-1:0]    m_ar_id,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    output logic [1:0]          m_ar_burst,
    output logic [CNT_W-1:0]    accepted_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int ENTRY_W = UID_W + ADDR_W + 8 + 3 + 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e               occ_q;
    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [CNT_W-1:0]   accepted_q, accepted_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic space;
    logic push;
    logic pop;
    logic stall;

    // Space comes from registered occupancy only, so m_ar_ready never
    // reaches s_ar_ready; a full FIFO refuses even when it is popping.
    assign space      = (occ_q != FULL);
    assign alloc_req  = s_ar_valid & space;
    assign in_orig_id = s_ar_id;
    assign s_ar_ready = space & alloc_gnt;
    assign push       = s_ar_valid & s_ar_ready;
    assign stall      = s_ar_valid & space & ~alloc_gnt;

    assign m_ar_valid = (occ_q != EMPTY);
    assign pop        = m_ar_valid & m_ar_ready;

    assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst} = mem_q[rd_ptr_q];

    assign accepted_cnt = accepted_q;
    assign stall_cnt    = stall_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        accepted_d = accepted_q;
        stall_d    = stall_q;
        if (push && (accepted_q != {CNT_W{1'b1}})) begin
            accepted_d = accepted_q + 1'b1;
        end
        if (stall && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            accepted_q <= '0;
            stall_q    <= '0;
            // NOTE: payload storage is cleared as well, because the m_ar_*
            // data outputs are read straight from it and must be 0 after reset.
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            accepted_q <= accepted_d;
            stall_q    <= stall_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {unique_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (occ_q)
                EMPTY: if (push) occ_q <= ONE;
                ONE: begin
                    if (push && !pop) begin
                        occ_q <= FULL;
                    end else if (pop && !push) begin
                        occ_q <= EMPTY;
                    end
                end
                FULL:    if (pop) occ_q <= ONE;
                default: occ_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ar_id_remapper.sv
// Directed bench for ar_id_remapper: stimulus pushes expected AR beats into a
// queue, an independent monitor pops and compares whenever the DUT pops.
module tb_ar_id_remapper;

    localparam int ID_WIDTH = 4;
    localparam int UID_W    = 6;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 4;
    localparam int ENTRY_W  = UID_W + ADDR_W + 13;

    logic                clk;
    logic                rst;
    logic                s_ar_valid;
    logic                s_ar_ready;
    logic [ID_WIDTH-1:0] s_ar_id;
    logic [ADDR_W-1:0]   s_ar_addr;
    logic [7:0]          s_ar_len;
    logic [2:0]          s_ar_size;
    logic [1:0]          s_ar_burst;
    logic                alloc_req;
    logic [ID_WIDTH-1:0] in_orig_id;
    logic                alloc_gnt;
    logic [UID_W-1:0]    unique_id;
    logic                m_ar_valid;
    logic                m_ar_ready;
    logic [UID_W-1:0]    m_ar_id;
    logic [ADDR_W-1:0]   m_ar_addr;
    logic [7:0]          m_ar_len;
    logic [2:0]          m_ar_size;
    logic [1:0]          m_ar_burst;
    logic [CNT_W-1:0]    accepted_cnt;
    logic [CNT_W-1:0]    stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [ENTRY_W-1:0] exp_q [$];

    ar_id_remapper #(
        .ID_WIDTH(ID_WIDTH),
        .UID_W   (UID_W),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_ar_valid  (s_ar_valid),
        .s_ar_ready  (s_ar_ready),
        .s_ar_id     (s_ar_id),
        .s_ar_addr   (s_ar_addr),
        .s_ar_len    (s_ar_len),
        .s_ar_size   (s_ar_size),
        .s_ar_burst  (s_ar_burst),
        .alloc_req   (alloc_req),
        .in_orig_id  (in_orig_id),
        .alloc_gnt   (alloc_gnt),
        .unique_id   (unique_id),
        .m_ar_valid  (m_ar_valid),
        .m_ar_ready  (m_ar_ready),
        .m_ar_id     (m_ar_id),
        .m_ar_addr   (m_ar_addr),
        .m_ar_len    (m_ar_len),
        .m_ar_size   (m_ar_size),
        .m_ar_burst  (m_ar_burst),
        .accepted_cnt(accepted_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive after the posedge, check combinational handshake at
    // the negedge and record the beat expected downstream when accepted.
    task automatic step(input logic v, input logic [3:0] id, input logic [31:0] addr,
                        input logic gnt, input logic [5:0] uid, input logic mr,
                        input logic exp_rdy, input logic exp_req);
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        len   = {2'b00, uid};
        size  = uid[2:0];
        burst = uid[0] ? 2'b01 : 2'b10;
        @(posedge clk);
        #1;
        s_ar_valid = v;
        s_ar_id    = id;
        s_ar_addr  = addr;
        s_ar_len   = len;
        s_ar_size  = size;
        s_ar_burst = burst;
        alloc_gnt  = gnt;
        unique_id  = uid;
        m_ar_ready = mr;
        @(negedge clk);
        check("s_ar_ready", 64'(s_ar_ready), 64'(exp_rdy));
        check("alloc_req", 64'(alloc_req), 64'(exp_req));
        if (v) check("in_orig_id", 64'(in_orig_id), 64'(id));
        if (v && exp_rdy) exp_q.push_back({uid, addr, len, size, burst});
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 4'h0, 32'h0, 1'b0, 6'h0, mr, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        s_ar_valid = 1'b0;
        alloc_gnt  = 1'b0;
        m_ar_ready = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("rst_m_ar_data", 64'({m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst}), 64'd0);
        check("rst_accepted_cnt", 64'(accepted_cnt), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    endtask

    // Monitor: compares every popped beat and enforces AXI stability.
    initial begin
        logic               hold_v;
        logic [ENTRY_W-1:0] hold_d;
        logic [ENTRY_W-1:0] cur;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            cur = {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst};
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", 64'(m_ar_valid), 64'd1);
                    check("hold_data", 64'(cur), 64'(hold_d));
                end
                if (m_ar_valid && m_ar_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 64'(cur), 64'hffff_ffff_ffff_ffff);
                    end else begin
                        check("pop_data", 64'(cur), 64'(exp_q.pop_front()));
                    end
                end
                hold_v = m_ar_valid && !m_ar_ready;
                hold_d = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        s_ar_valid = 1'b0;
        s_ar_id    = '0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_size  = '0;
        s_ar_burst = '0;
        alloc_gnt  = 1'b0;
        unique_id  = '0;
        m_ar_ready = 1'b0;
        do_reset();

        // Single request, visible downstream the next cycle.
        step(1'b1, 4'h3, 32'h1000, 1'b1, 6'h05, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check("single_valid", 64'(m_ar_valid), 64'd1);
        check("single_id", 64'(m_ar_id), 64'h05);
        check("single_addr", 64'(m_ar_addr), 64'h1000);
        check("single_accepted", 64'(accepted_cnt), 64'd1);

        // Backpressure: two fill the FIFO, the third waits until after a pop.
        step(1'b1, 4'h1, 32'h2000, 1'b1, 6'h0a, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h2, 32'h2040, 1'b1, 6'h0b, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h7, 32'h2080, 1'b1, 6'h0c, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'h2080, 1'b1, 6'h0c, 1'b0, 1'b0, 1'b0);
        check("bp_head_id", 64'(m_ar_id), 64'h0a);
        step(1'b1, 4'h7, 32'h2080, 1'b1, 6'h0c, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'h2080, 1'b1, 6'h0c, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("bp_accepted", 64'(accepted_cnt), 64'd4);
        check("bp_drained", 64'(m_ar_valid), 64'd0);

        // Allocator full for five cycles, then granted.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'h9, 32'h3000, 1'b0, 6'h3f, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 4'h9, 32'h3000, 1'b1, 6'h14, 1'b1, 1'b1, 1'b1);
        check("stall_five", 64'(stall_cnt), 64'd5);
        idle(1'b1);
        check("stall_hold", 64'(stall_cnt), 64'd5);
        check("stall_accepted", 64'(accepted_cnt), 64'd5);

        // Streaming push+pop at occupancy 1: one beat per cycle.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(i), 32'h4000 + 32'(i * 64), 1'b1, 6'(i + 1), 1'b1, 1'b1, 1'b1);
            if (i > 0) check("stream_valid", 64'(m_ar_valid), 64'd1);
        end
        idle(1'b1);
        check("stream_accepted", 64'(accepted_cnt), 64'd11);

        // Reset while full discards the buffered beats.
        step(1'b1, 4'h4, 32'h5000, 1'b1, 6'h1e, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h5, 32'h5040, 1'b1, 6'h1f, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h6, 32'h5080, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0);
        check("full_accepted", 64'(accepted_cnt), 64'd13);
        do_reset();
        step(1'b0, 4'h0, 32'h0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 64'(m_ar_valid), 64'd0);

        // Saturation of the 4-bit accepted counter.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'(i), 32'h6000 + 32'(i), 1'b1, 6'(i), 1'b1, 1'b1, 1'b1);
            check("sat_accepted", 64'(accepted_cnt), 64'((i < 15) ? i : 15));
        end
        idle(1'b1);
        check("sat_final", 64'(accepted_cnt), 64'd15);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            idle(1'b1);
        end
        @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
